game_timer: RTL and testbench
=============================

Name: game_timer

Overview:
- Parametrised successor to the 0.1 s game clock: a tick prescaler on CLOCK10M drives a WIDTH-bit game counter.
- Counter counts up or down with start/stop/pause, preload, lap capture, and terminal detection (expire or wrap).
- Sits between the board clock/keys and the game logic and display drivers; counter_out is the game time in ticks.

Parameters:
- CLK_HZ, 10000000, input clock frequency in Hz.
- TICK_HZ, 10, counter update rate in Hz. Derived TICK_DIV = CLK_HZ/TICK_HZ; TICK_DIV must be >= 2 (elaboration error otherwise).
- WIDTH, 10, counter width in bits.
- MAX_COUNT, 2**WIDTH-1, terminal value in up mode and wrap target in down mode.
- WRAP, 0, terminal behaviour: 0 = stop in EXPIRED; 1 = wrap around and keep running.

Ports:
- CLOCK10M  in  1  system clock; all logic on its rising edge.
- KEY0  in  1  reset, asynchronous, active-high.
- START  in  1  1-cycle command: begin or resume counting.
- STOP  in  1  1-cycle command: pause counting.
- CLEAR  in  1  1-cycle synchronous clear.
- LOAD  in  1  1-cycle command: preload LOAD_VALUE.
- LOAD_VALUE  in  WIDTH  preload value.
- MODE_DOWN  in  1  0 = count up, 1 = count down; sampled at every tick.
- LAP  in  1  1-cycle command: capture counter_out.
- counter_out  out  WIDTH  current count.
- lap_out  out  WIDTH  last captured count.
- lap_valid  out  1  1-cycle pulse, the cycle after a capture.
- tick  out  1  1-cycle pulse, coincident with each counter update.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- expired  out  1  high in EXPIRED.
- term_pulse  out  1  1-cycle pulse on reaching terminal value or wrapping.

Behaviour:
- Reset (KEY0=1, any time, including mid-run): state IDLE, prescaler 0, and all outputs 0 (counter_out, lap_out, lap_valid, tick, running, paused, expired, term_pulse).
- States:
  - IDLE: START -> RUN.
  - RUN: STOP -> PAUSE; reaching terminal with WRAP=0 -> EXPIRED.
  - PAUSE: START -> RUN.
  - EXPIRED: START and STOP ignored; only CLEAR or LOAD leave it.
- Command priority in one cycle: CLEAR > LOAD > STOP > START.
  - CLEAR: counter_out<=0, prescaler<=0, state IDLE.
  - LOAD: counter_out<=min(LOAD_VALUE, MAX_COUNT), prescaler<=0, state IDLE.
  - Both override a tick in the same cycle.
- Prescaler:
  - In RUN it counts 0..TICK_DIV-1. On the edge where it equals TICK_DIV-1, it returns to 0 and counter_out updates; tick is high during the following cycle.
  - First update comes TICK_DIV cycles after the START edge.
  - In PAUSE the prescaler holds, so resume continues the partial period.
  - In IDLE and EXPIRED it is 0.
- Update on tick, using MODE_DOWN at that edge:
  - Up: count+1. If the result equals MAX_COUNT: term_pulse=1; with WRAP=0, state -> EXPIRED. With WRAP=1, MAX_COUNT -> 0 on the next tick.
  - Down: count-1. If the result equals 0: term_pulse=1; with WRAP=0, state -> EXPIRED. With WRAP=1, 0 -> MAX_COUNT on the next tick.
  - With WRAP=1, term_pulse fires when terminal is reached, not again on the wrap itself.
- START with the count already at terminal (up and count=MAX_COUNT, or down and count=0) and WRAP=0: state -> EXPIRED next cycle, term_pulse=1, no tick, count unchanged.
- STOP on the same edge as a tick: the tick update completes, then state -> PAUSE.
- LAP in any state:
  - lap_out<=counter_out value before any same-edge update; lap_valid=1 the next cycle.
  - LAP during reset is ignored.
- Counter arithmetic is modulo 2**WIDTH internally, but the value never exceeds MAX_COUNT.
- Outputs are registered; running/paused/expired are decoded from the state register and are mutually exclusive.

Test Plan:
- Use CLK_HZ=40, TICK_HZ=10 (TICK_DIV=4), WIDTH=4, MAX_COUNT=5, WRAP=0. Reset, START -> tick every 4 cycles, first 4 cycles after START. counter_out goes 1..5; at 5, term_pulse=1 once, expired=1, no further ticks; START ignored.
- Same config, START, STOP 2 cycles into a period, wait 10 cycles, START -> count unchanged while paused; next tick exactly 2 cycles after resume.
- LOAD_VALUE=3, MODE_DOWN=1, START -> counter_out 2, 1, 0; term_pulse at 0; expired. CLEAR -> counter_out=0, IDLE. LOAD_VALUE=9 -> counter_out=5 (saturated).
- WRAP=1, up mode -> sequence 1..5, term_pulse at 5, then 0, 1...; expired stays 0.
- LAP on the same edge as a tick that moves 2->3 -> lap_out=2, lap_valid for 1 cycle. CLEAR+LOAD+START together -> CLEAR wins, count 0, IDLE.
- Assert KEY0 asynchronously mid-period while RUN at count 4 -> all outputs 0 immediately (before the next clock edge); after release, START gives its first tick 4 cycles later.

Source files
------------

// File: rtl/game_timer.sv
// game_timer: prescaled game-time counter with up/down counting,
// start/stop/pause, preload, lap capture and terminal expire or wrap.
module game_timer #(
    parameter int          CLK_HZ    = 10000000,
    parameter int          TICK_HZ   = 10,
    parameter int          WIDTH     = 10,
    parameter int unsigned MAX_COUNT = 2**WIDTH - 1,
    parameter int          WRAP      = 0
) (
    input  logic             CLOCK10M,
    input  logic             KEY0,
    input  logic             START,
    input  logic             STOP,
    input  logic             CLEAR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    input  logic             MODE_DOWN,
    input  logic             LAP,
    output logic [WIDTH-1:0] counter_out,
    output logic [WIDTH-1:0] lap_out,
    output logic             lap_valid,
    output logic             tick,
    output logic             running,
    output logic             paused,
    output logic             expired,
    output logic             term_pulse
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] MAXV       = WIDTH'(MAX_COUNT);
    localparam bit               WRAP_EN    = (WRAP != 0);

    if (TICK_DIV < 2) begin : g_div_check
        $error("game_timer: CLK_HZ/TICK_HZ must be at least 2");
    end

    if (MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH - 1) begin : g_max_check
        $error("game_timer: MAX_COUNT must lie in 1 .. 2**WIDTH-1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_nx;
    logic [WIDTH-1:0] count_nx;
    logic             tick_nx;
    logic             term_nx;

    logic [WIDTH-1:0] step;
    logic             step_term;
    logic             at_term;
    logic             period_end;
    logic [WIDTH-1:0] load_sat;

    // Next count for one tick in the current direction, kept within 0..MAX_COUNT
    always_comb begin
        if (MODE_DOWN) begin
            step      = (counter_out == '0) ? MAXV : counter_out - 1'b1;
            step_term = (step == '0);
            at_term   = (counter_out == '0);
        end else begin
            step      = (counter_out >= MAXV) ? '0 : counter_out + 1'b1;
            step_term = (step == MAXV);
            at_term   = (counter_out == MAXV);
        end
        period_end = (presc == PRESC_LAST);
        load_sat   = (LOAD_VALUE > MAXV) ? MAXV : LOAD_VALUE;
    end

    // State, prescaler, counter and pulse registers
    always_ff @(posedge CLOCK10M or posedge KEY0) begin
        if (KEY0) begin
            state       <= IDLE;
            presc       <= '0;
            counter_out <= '0;
            tick        <= 1'b0;
            term_pulse  <= 1'b0;
        end else begin
            state       <= state_nx;
            presc       <= presc_nx;
            counter_out <= count_nx;
            tick        <= tick_nx;
            term_pulse  <= term_nx;
        end
    end

    // Next-state logic: CLEAR > LOAD > STOP > START, then tick handling
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        count_nx = counter_out;
        tick_nx  = 1'b0;
        term_nx  = 1'b0;
        if (CLEAR) begin
            state_nx = IDLE;
            presc_nx = '0;
            count_nx = '0;
        end else if (LOAD) begin
            state_nx = IDLE;
            presc_nx = '0;
            count_nx = load_sat;
        end else begin
            unique case (state)
                RUN: begin
                    if (period_end) begin
                        presc_nx = '0;
                        count_nx = step;
                        tick_nx  = 1'b1;
                        term_nx  = step_term;
                    end else begin
                        presc_nx = presc + 1'b1;
                    end
                    if (period_end && step_term && !WRAP_EN) begin
                        state_nx = EXPIRED;
                    end else if (STOP) begin
                        state_nx = PAUSE;
                    end
                end
                IDLE, PAUSE: begin
                    if (!STOP && START) begin
                        if (at_term && !WRAP_EN) begin
                            state_nx = EXPIRED;
                            presc_nx = '0;
                            term_nx  = 1'b1;
                        end else begin
                            state_nx = RUN;
                        end
                    end
                end
                EXPIRED: begin
                    state_nx = EXPIRED;
                end
                default: begin
                    state_nx = IDLE;
                    presc_nx = '0;
                end
            endcase
        end
    end

    // Status flags decoded from the state register
    always_comb begin
        running = (state == RUN);
        paused  = (state == PAUSE);
        expired = (state == EXPIRED);
    end

    // Lap capture samples the count before any same-edge update
    always_ff @(posedge CLOCK10M or posedge KEY0) begin
        if (KEY0) begin
            lap_out   <= '0;
            lap_valid <= 1'b0;
        end else begin
            lap_valid <= LAP;
            if (LAP) begin
                lap_out <= counter_out;
            end
        end
    end

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: two instances (expire and wrap)
// share stimulus; a reference model predicts every cycle.
module tb_game_timer;

    localparam int MAXC = 5;
    localparam int DIV  = 4;

    logic       clk = 1'b0;
    logic       KEY0 = 1'b1;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       CLEAR = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] LOAD_VALUE = 4'd0;
    logic       MODE_DOWN = 1'b0;
    logic       LAP = 1'b0;

    logic [3:0] co0, lo0, co1, lo1;
    logic       lv0, tk0, rn0, pa0, ex0, tp0;
    logic       lv1, tk1, rn1, pa1, ex1, tp1;

    typedef struct {
        int cnt;
        int phase;
        bit run;
        bit pause;
        bit expd;
        int lap;
        bit lapv;
        bit tk;
        bit term;
    } mdl_t;

    mdl_t m0, m1;
    mdl_t q0[$];
    mdl_t q1[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    game_timer #(.CLK_HZ(40), .TICK_HZ(10), .WIDTH(4),
                 .MAX_COUNT(MAXC), .WRAP(0)) dut0 (
        .CLOCK10M(clk), .KEY0(KEY0), .START(START), .STOP(STOP),
        .CLEAR(CLEAR), .LOAD(LOAD), .LOAD_VALUE(LOAD_VALUE),
        .MODE_DOWN(MODE_DOWN), .LAP(LAP), .counter_out(co0),
        .lap_out(lo0), .lap_valid(lv0), .tick(tk0), .running(rn0),
        .paused(pa0), .expired(ex0), .term_pulse(tp0)
    );

    game_timer #(.CLK_HZ(40), .TICK_HZ(10), .WIDTH(4),
                 .MAX_COUNT(MAXC), .WRAP(1)) dut1 (
        .CLOCK10M(clk), .KEY0(KEY0), .START(START), .STOP(STOP),
        .CLEAR(CLEAR), .LOAD(LOAD), .LOAD_VALUE(LOAD_VALUE),
        .MODE_DOWN(MODE_DOWN), .LAP(LAP), .counter_out(co1),
        .lap_out(lo1), .lap_valid(lv1), .tick(tk1), .running(rn1),
        .paused(pa1), .expired(ex1), .term_pulse(tp1)
    );

    // Reference: time advances in whole periods of DIV running cycles;
    // the count moves modulo MAXC+1 and the terminal is MAXC (up) or 0 (down).
    function automatic mdl_t model(input mdl_t m, input bit rst,
                                   input bit st, input bit sp,
                                   input bit cl, input bit ld,
                                   input int lv, input bit md,
                                   input bit lp, input bit wrap);
        mdl_t n;
        int   nxt;
        bit   hit;
        n = m;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        n.lapv = lp;
        if (lp) n.lap = m.cnt;
        n.tk   = 0;
        n.term = 0;
        if (cl || ld) begin
            n.cnt   = cl ? 0 : (lv > MAXC ? MAXC : lv);
            n.phase = 0;
            n.run   = 0;
            n.pause = 0;
            n.expd  = 0;
            return n;
        end
        if (m.run) begin
            n.phase = m.phase + 1;
            if (n.phase == DIV) begin
                n.phase = 0;
                n.tk    = 1;
                nxt     = md ? (m.cnt + MAXC) % (MAXC + 1)
                             : (m.cnt + 1) % (MAXC + 1);
                n.cnt   = nxt;
                hit     = md ? (nxt == 0) : (nxt == MAXC);
                n.term  = hit;
                if (hit && !wrap) begin
                    n.run  = 0;
                    n.expd = 1;
                    return n;
                end
            end
            if (sp) begin
                n.run   = 0;
                n.pause = 1;
            end
        end else if (!m.expd && !sp && st) begin
            n.pause = 0;
            if (!wrap && (md ? (m.cnt == 0) : (m.cnt == MAXC))) begin
                n.expd  = 1;
                n.term  = 1;
                n.phase = 0;
            end else begin
                n.run = 1;
            end
        end
        return n;
    endfunction

    task automatic cmp(input string nm, input mdl_t e,
                       input logic [3:0] co, input logic [3:0] lo,
                       input logic lv, input logic tk, input logic rn,
                       input logic pa, input logic ex, input logic tp);
        tests++;
        if (co !== 4'(e.cnt) || lo !== 4'(e.lap) || lv !== e.lapv ||
            tk !== e.tk || rn !== e.run || pa !== e.pause ||
            ex !== e.expd || tp !== e.term) begin
            fails++;
            $display("FAIL %s cyc=%0d got cnt=%0d lap=%0d lv=%b tk=%b run=%b pau=%b exp=%b term=%b want cnt=%0d lap=%0d lv=%b tk=%b run=%b pau=%b exp=%b term=%b",
                     nm, cyc, co, lo, lv, tk, rn, pa, ex, tp,
                     e.cnt, e.lap, e.lapv, e.tk, e.run, e.pause,
                     e.expd, e.term);
        end
    endtask

    // Monitor: every edge, pop the prediction and compare both instances
    always @(posedge clk) begin
        #1;
        cyc++;
        if (q0.size() > 0) cmp("wrap0", q0.pop_front(), co0, lo0,
                               lv0, tk0, rn0, pa0, ex0, tp0);
        if (q1.size() > 0) cmp("wrap1", q1.pop_front(), co1, lo1,
                               lv1, tk1, rn1, pa1, ex1, tp1);
    end

    task automatic drive(input bit rst, input bit st, input bit sp,
                         input bit cl, input bit ld, input int lv,
                         input bit md, input bit lp);
        @(negedge clk);
        KEY0       = rst;
        START      = st;
        STOP       = sp;
        CLEAR      = cl;
        LOAD       = ld;
        LOAD_VALUE = 4'(lv);
        MODE_DOWN  = md;
        LAP        = lp;
        m0 = model(m0, rst, st, sp, cl, ld, lv, md, lp, 1'b0);
        m1 = model(m1, rst, st, sp, cl, ld, lv, md, lp, 1'b1);
        q0.push_back(m0);
        q1.push_back(m1);
    endtask

    task automatic idle(input int n, input bit md);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, md, 0);
    endtask

    // Raise reset between edges and require all outputs cleared at once
    task automatic async_rst();
        mdl_t z;
        z = '{default: 0};
        @(negedge clk);
        #2;
        KEY0  = 1'b1;
        START = 1'b0; STOP = 1'b0; CLEAR = 1'b0; LOAD = 1'b0; LAP = 1'b0;
        #1;
        cmp("async_rst0", z, co0, lo0, lv0, tk0, rn0, pa0, ex0, tp0);
        cmp("async_rst1", z, co1, lo1, lv1, tk1, rn1, pa1, ex1, tp1);
        m0 = z;
        m1 = z;
        q0.push_back(z);
        q1.push_back(z);
    endtask

    initial begin
        bit md;
        m0 = '{default: 0};
        m1 = '{default: 0};
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        drive(0, 1, 0, 0, 0, 0, 0, 0);
        idle(26, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        idle(6, 0);

        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        idle(1, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        idle(10, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        idle(6, 0);

        drive(0, 0, 0, 0, 1, 3, 1, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 0);
        idle(16, 1);
        drive(0, 0, 0, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 9, 0, 0);
        idle(2, 0);

        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        idle(11, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2, 0);
        drive(0, 1, 0, 1, 1, 4, 0, 0);
        idle(2, 0);

        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        idle(18, 0);
        async_rst();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        idle(6, 0);

        md = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) md = ~md;
            if ($urandom_range(399) == 0) begin
                async_rst();
            end else begin
                drive($urandom_range(299) == 0,
                      $urandom_range(5) == 0,
                      $urandom_range(11) == 0,
                      $urandom_range(59) == 0,
                      $urandom_range(39) == 0,
                      int'($urandom_range(15)),
                      md,
                      $urandom_range(7) == 0);
            end
        end
        idle(3, md);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
